// File: rtl/median3x3_window_ctrl.sv
// Streaming 3x3 median filter controller: two line buffers, a 3x3 sliding
// window and a 9-input median sorting network. One output pixel is produced
// per fully interior window, giving a cropped (IMG_W-2) x (IMG_H-2) frame.

// 9-input median via the classic 19 compare-exchange network (min to LO slot).
module median9_sortnet (
  input  logic [71:0] din,
  output logic [7:0]  med
);
  localparam int N_CMP = 19;
  localparam int LO [N_CMP] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0, 5, 4, 3, 1, 2, 4, 4, 6, 4};
  localparam int HI [N_CMP] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3, 8, 7, 6, 4, 5, 7, 2, 4, 2};

  // Run the compare-exchange sequence; the median settles in slot 4.
  always_comb begin : sort_net
    logic [7:0] p [9];
    logic [7:0] t;
    t = '0;
    for (int i = 0; i < 9; i++) begin
      p[i] = din[8*i +: 8];
    end
    for (int k = 0; k < N_CMP; k++) begin
      if (p[LO[k]] > p[HI[k]]) begin
        t        = p[LO[k]];
        p[LO[k]] = p[HI[k]];
        p[HI[k]] = t;
      end
    end
    med = p[4];
  end
endmodule

module median3x3_window_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       frame_done
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    lb1 [IMG_W];
  logic [7:0]    lb2 [IMG_W];
  logic [7:0]    win0 [3];
  logic [7:0]    win1 [3];
  logic [7:0]    newc [3];
  logic [7:0]    med;
  logic          accept;
  logic          col_end;
  logic          row_end;
  logic          emit;

  // A stalled output blocks input; clr also refuses the pixel in its cycle.
  assign s_ready = !clr && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;
  assign col_end = (col == COL_MAX);
  assign row_end = (row == ROW_MAX);
  assign emit    = accept && (row >= RW'(2)) && (col >= CW'(2));

  // Incoming column, top to bottom: row-2, row-1, current pixel.
  assign newc[0] = lb2[col];
  assign newc[1] = lb1[col];
  assign newc[2] = s_data;

  median9_sortnet u_sortnet (
    .din ({newc[2], newc[1], newc[0], win1[2], win1[1], win1[0], win0[2], win0[1], win0[0]}),
    .med (med)
  );

  // Raster position of the next pixel to accept; wraps at exact frame size.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffers shift down one row per accepted pixel; never cleared.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col] <= lb1[col];
      lb1[col] <= s_data;
    end
  end

  // Sliding window keeps the two previous columns; stale columns at row
  // start are never emitted because output waits for col >= 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        win0[i] <= '0;
        win1[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win0[i] <= win1[i];
        win1[i] <= newc[i];
      end
    end
  end

  // Output register: load on interior accept, drop on handshake, hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
    end else if (clr) begin
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= emit && row_end && col_end;
      if (emit) begin
        m_valid <= 1'b1;
        m_data  <= med;
        m_last  <= row_end && col_end;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_median3x3_window_ctrl.sv
// Bench for median3x3_window_ctrl: table-driven 5x5 frames, backpressure,
// abort by clr/rst, and randomized 7x4 frames against a software median model.
`timescale 1ns/1ps
module tb_median3x3_window_ctrl;
  localparam int AW = 5, AH = 5, BW = 7, BH = 4;

  typedef int pix_q[$];
  typedef struct { int data; bit last; } out_t;
  typedef struct { int kind; int exp[9]; } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_clr, a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_m_last, a_frame_done;
  logic [7:0] a_s_data, a_m_data;
  logic b_clr, b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_m_last, b_frame_done;
  logic [7:0] b_s_data, b_m_data;

  median3x3_window_ctrl #(.IMG_W(AW), .IMG_H(AH)) dut_a (
    .clk(clk), .rst(rst), .clr(a_clr), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .s_data(a_s_data), .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .m_last(a_m_last), .frame_done(a_frame_done));

  median3x3_window_ctrl #(.IMG_W(BW), .IMG_H(BH)) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .s_data(b_s_data), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .m_last(b_m_last), .frame_done(b_frame_done));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0d", name, act);
    end
  endtask

  // Output collectors: a transfer happens at the edge after valid && ready is seen.
  out_t qa[$], qb[$];
  int fd_a = 0, fd_b = 0, acc_a = 0;
  always @(negedge clk) begin
    if (a_m_valid && a_m_ready) qa.push_back(out_t'{int'(a_m_data), a_m_last});
    if (b_m_valid && b_m_ready) qb.push_back(out_t'{int'(b_m_data), b_m_last});
    if (a_s_valid && a_s_ready) acc_a++;
    if (a_frame_done) begin
      fd_a++;
      check("a_frame_done_with_last", {30'd0, a_m_valid, a_m_last}, 32'd3);
    end
    if (b_frame_done) begin
      fd_b++;
      check("b_frame_done_with_last", {30'd0, b_m_valid, b_m_last}, 32'd3);
    end
  end

  // Random sink stalls for DUT B.
  bit rb_en = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rb_en) b_m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Reference median: the value whose rank covers position 4 of 9.
  function automatic int med9(input int v[9]);
    for (int i = 0; i < 9; i++) begin
      int lt, le;
      lt = 0; le = 0;
      for (int j = 0; j < 9; j++) begin
        if (v[j] < v[i]) lt++;
        if (v[j] <= v[i]) le++;
      end
      if (lt <= 4 && le >= 5) return v[i];
    end
    return -1;
  endfunction

  function automatic pix_q ref_out(input pix_q f, input int w, input int h);
    pix_q r;
    int v[9];
    for (int y = 1; y < h - 1; y++) begin
      for (int x = 1; x < w - 1; x++) begin
        for (int k = 0; k < 9; k++) v[k] = f[(y + k / 3 - 1) * w + x + k % 3 - 1];
        r.push_back(med9(v));
      end
    end
    return r;
  endfunction

  function automatic pix_q mk_frame(input int kind);
    pix_q f;
    for (int i = 0; i < AW * AH; i++) begin
      case (kind)
        0:       f.push_back((i / AW) * 5 + i % AW);
        1:       f.push_back((i == 12) ? 255 : (i == 8) ? 0 : 100);
        2:       f.push_back(42);
        default: f.push_back(int'($urandom_range(0, 255)));
      endcase
    end
    return f;
  endfunction

  // Offer the first n pixels of f to DUT A; called and returns at posedge+1.
  task automatic send_a(input pix_q f, input int n);
    int i, guard;
    i = 0; guard = 0;
    while (i < n && guard < 2000) begin
      a_s_valid = 1'b1;
      a_s_data  = 8'(f[i]);
      @(negedge clk);
      if (a_s_ready) i++;
      @(posedge clk); #1;
      guard++;
    end
    a_s_valid = 1'b0;
    check("a_send_complete", i, n);
  endtask

  task automatic send_b(input pix_q f);
    int i, guard;
    i = 0; guard = 0;
    while (i < f.size() && guard < 5000) begin
      b_s_valid = ($urandom_range(0, 3) != 0);
      b_s_data  = 8'(f[i]);
      @(negedge clk);
      if (b_s_valid && b_s_ready) i++;
      @(posedge clk); #1;
      guard++;
    end
    b_s_valid = 1'b0;
    check("b_send_complete", i, f.size());
  endtask

  task automatic compare_q(input string tag, input out_t q[$], input pix_q exp, input int per_frame);
    check({tag, "_count"}, q.size(), exp.size());
    for (int k = 0; k < exp.size() && k < q.size(); k++) begin
      check($sformatf("%s_data[%0d]", tag, k), q[k].data, exp[k]);
      check($sformatf("%s_last[%0d]", tag, k), {31'd0, q[k].last}, ((k + 1) % per_frame == 0) ? 1 : 0);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t tbl[3];
  pix_q ramp_exp;

  initial begin
    pix_q exp, f;
    int fd0, acc0, found;
    logic [7:0] held;

    tbl[0].kind = 0; tbl[0].exp = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
    tbl[1].kind = 2; tbl[1].exp = '{42, 42, 42, 42, 42, 42, 42, 42, 42};
    tbl[2].kind = 1; tbl[2].exp = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    for (int k = 0; k < 9; k++) ramp_exp.push_back(tbl[0].exp[k]);

    rst = 1'b1;
    a_clr = 1'b0; a_s_valid = 1'b0; a_s_data = '0; a_m_ready = 1'b1;
    b_clr = 1'b0; b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_m_valid", a_m_valid, 0);
    check("rst_m_data", a_m_data, 0);
    check("rst_m_last", a_m_last, 0);
    check("rst_frame_done", a_frame_done, 0);
    check("rst_s_ready", a_s_ready, 1);
    check("rst_b_s_ready", b_s_ready, 1);
    @(posedge clk); #1;

    // Table frames sent back-to-back: ramp, constant 42, impulse noise.
    qa.delete(); fd0 = fd_a; acc0 = acc_a;
    for (int t = 0; t < 3; t++) begin
      send_a(mk_frame(tbl[t].kind), AW * AH);
      for (int k = 0; k < 9; k++) exp.push_back(tbl[t].exp[k]);
    end
    drain(5);
    compare_q("table", qa, exp, 9);
    check("table_frame_done_count", fd_a - fd0, 3);
    check("table_accepts", acc_a - acc0, 3 * AW * AH);

    // Backpressure: stall the sink for 3 cycles while output 11 is pending.
    qa.delete(); fd0 = fd_a; acc0 = acc_a;
    fork
      send_a(mk_frame(0), AW * AH);
      begin
        found = 0;
        for (int t = 0; t < 200 && found == 0; t++) begin
          @(posedge clk); #1;
          if (a_m_valid && a_m_data == 8'd11) found = 1;
        end
        check("bp_found_11", found, 1);
        a_m_ready = 1'b0;
        held = a_m_data;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("bp_m_data_stable", a_m_data, held);
          check("bp_m_valid_held", a_m_valid, 1);
          check("bp_s_ready_low", a_s_ready, 0);
        end
        @(posedge clk); #1;
        a_m_ready = 1'b1;
      end
    join
    drain(5);
    compare_q("bp", qa, ramp_exp, 9);
    check("bp_accepts", acc_a - acc0, AW * AH);
    check("bp_frame_done_count", fd_a - fd0, 1);

    // Abort with clr after 13 accepts, then a clean ramp.
    send_a(mk_frame(3), 13);
    a_clr = 1'b1; a_s_valid = 1'b1; a_s_data = 8'd99;
    @(negedge clk);
    check("clr_s_ready", a_s_ready, 0);
    @(posedge clk); #1;
    a_clr = 1'b0; a_s_valid = 1'b0;
    check("clr_m_valid", a_m_valid, 0);
    check("clr_m_last", a_m_last, 0);
    qa.delete(); fd0 = fd_a;
    send_a(mk_frame(0), AW * AH);
    drain(5);
    compare_q("clr", qa, ramp_exp, 9);
    check("clr_frame_done_count", fd_a - fd0, 1);

    // Abort with an asynchronous rst pulse mid-cycle.
    send_a(mk_frame(3), 13);
    #1 rst = 1'b1;
    #1;
    check("arst_m_valid", a_m_valid, 0);
    check("arst_m_data", a_m_data, 0);
    check("arst_m_last", a_m_last, 0);
    check("arst_frame_done", a_frame_done, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    qa.delete(); fd0 = fd_a;
    send_a(mk_frame(0), AW * AH);
    drain(5);
    compare_q("arst", qa, ramp_exp, 9);
    check("arst_frame_done_count", fd_a - fd0, 1);

    // Random 7x4 frames with random source gaps and sink stalls.
    qb.delete(); exp.delete(); fd0 = fd_b;
    rb_en = 1;
    for (int fr = 0; fr < 3; fr++) begin
      f.delete();
      for (int i = 0; i < BW * BH; i++) f.push_back(int'($urandom_range(0, 255)));
      exp = {exp, ref_out(f, BW, BH)};
      send_b(f);
    end
    rb_en = 0;
    @(posedge clk); #1;
    b_m_ready = 1'b1;
    drain(10);
    compare_q("rand", qb, exp, (BW - 2) * (BH - 2));
    check("rand_frame_done_count", fd_b - fd0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
